stage_multiwave_generator: RTL
==============================

# stage_multiwave_generator

Parametrised successor to the single-mode sine waveform stage. It converts an operator phase word into a signed sample in one of four selectable waveforms: sine from a quarter-wave table, triangle, sawtooth or square. Latency is a fixed three cycles, and the voice/operator sideband travels alongside the sample unchanged. It also owns a streaming table-load state machine, so the sine table can be filled at runtime through a valid-qualified data port. It sits between the phase accumulator stage and the envelope/mixing stages.

## Interface
Parameters:
- PHASE_WIDTH, 17: phase input width; MSB is the sign and is ignored
- SAMPLE_WIDTH, 16: signed output width; table entries hold SAMPLE_WIDTH-1 magnitude bits
- TABLE_ADDR_WIDTH, 14: quarter-wave table address width; depth = 2^TABLE_ADDR_WIDTH
- SIDEBAND_WIDTH, 24: width of the concatenated voice-operator ID, algorithm word and note-on passthrough
- Legal only if PHASE_WIDTH-1 >= TABLE_ADDR_WIDTH+2, PHASE_WIDTH-1 >= SAMPLE_WIDTH and SAMPLE_WIDTH-1 >= TABLE_ADDR_WIDTH

Ports:
- i_Clock  in  1  sole clock; all logic on the rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Valid  in  1  input sample valid
- i_Phase  in  PHASE_WIDTH  signed phase word
- i_WaveSelect  in  2  waveform select: 0 sine, 1 triangle, 2 sawtooth, 3 square
- i_Sideband  in  SIDEBAND_WIDTH  voice-operator/algorithm/note-on bundle
- o_Valid  out  1  output valid
- o_Waveform  out  SAMPLE_WIDTH  signed sample
- o_Sideband  out  SIDEBAND_WIDTH  delayed copy of i_Sideband
- i_LoadStart  in  1  one-cycle pulse that starts a table load
- i_LoadValid  in  1  i_LoadData valid this cycle
- i_LoadData  in  SAMPLE_WIDTH  table entry; MSB ignored
- o_Loading  out  1  load in progress
- o_LoadDone  out  1  one-cycle pulse after the last entry is written
- o_TableValid  out  1  a complete load has finished since reset

## Operation
Phase decode:
- U = i_Phase[PHASE_WIDTH-2:0], the unsigned position in the cycle
- q = top two bits of U (the quadrant)
- r = the next TABLE_ADDR_WIDTH bits of U

Waveform per mode:
- Sine: table address = q[0] ? ~r : r. Magnitude M = {0, entry}. Output = q[1] ? ~M : M (one's complement, matching the existing sine stage).
- Triangle: m = q[0] ? ~r : r, left-justified into SAMPLE_WIDTH-1 bits with zero fill. M = {0, m}. Output = q[1] ? ~M : M. No table access.
- Sawtooth: top SAMPLE_WIDTH bits of U with the MSB inverted, so U=0 gives the most negative value and U=all-ones gives the most positive.
- Square: q[1]=0 gives +max (0x7FFF); q[1]=1 gives -max (0x8000).

Table RAM and load FSM:
- Table RAM: single port, synchronous read, depth 2^TABLE_ADDR_WIDTH. A write takes the port in any cycle where a load write occurs.
- IDLE: o_Loading=0. A pulse on i_LoadStart clears the address counter and moves to LOADING.
- LOADING: o_Loading=1. On each i_LoadValid, write i_LoadData[SAMPLE_WIDTH-2:0] at the counter, then increment the counter. Cycles without i_LoadValid hold the counter.
- The write at address depth-1 moves to DONE.
- DONE: lasts one cycle. o_LoadDone=1 and o_TableValid is set. Then return to IDLE.
- i_LoadStart is ignored outside IDLE.
- A new load from IDLE clears o_TableValid on entry to LOADING.

Sine muting:
- A sine-mode sample whose stage 1 falls while o_Loading=1, or while o_TableValid=0, outputs 0.
- Its valid bit and sideband still propagate.
- Triangle, sawtooth and square are never muted.

## Timing
- Fixed latency of 3 cycles, i_Valid to o_Valid, with no stalls.
- Stage 1: decode the phase, register the table address, mode, negate flag, mute flag, valid and sideband.
- Stage 2: table read data registered; non-table waveforms computed and registered.
- Stage 3: mode mux and negation into o_Waveform.
- Throughput: one sample per cycle in every mode, including during a load.
- While i_Valid=0, o_Waveform and o_Sideband still update from the pipeline contents, but o_Valid=0.
- Load: a write on cycle n is readable by a lookup whose stage 1 is on cycle n+1 or later.
- Reset values: o_Valid, o_Waveform, o_Sideband, o_Loading, o_LoadDone and o_TableValid are all 0; FSM in IDLE; counter 0. All pipeline valid bits are cleared.
- Table contents are not cleared by reset. After reset, sine stays muted until a full reload completes.
- Reset during LOADING aborts immediately: no o_LoadDone pulse, and o_TableValid stays 0.
- i_LoadStart asserted together with i_Reset is ignored.

## Test plan
- Triangle, defaults: phases 0x00000, 0x04000, 0x08000, 0x0C000 with i_Valid=1. Outputs 3 cycles later are 0x0000, 0x7FFE, 0xFFFF, 0x8001. o_Sideband matches the input.
- Sawtooth/square: phase 0x00000 gives 0x8000 and 0x7FFF respectively. Phase 0x1FFFF gives 0x7FFF and 0x8000. The sign bit has no effect: 0x10000 behaves as 0x00000.
- Load, then sine: load entry[i]=i with gaps in i_LoadValid. Check o_LoadDone pulses exactly once, one cycle after the write to 0x3FFF, and o_TableValid rises. Then phase 0x00005 gives 0x0005 and phase 0x0C005 gives ~0x3FFA = 0xC005.
- Muting: issue sine lookups before any load and during a load. Output is 0 with o_Valid=1. Interleaved square samples are unaffected.
- Reset mid-load: after 100 writes, pulse i_Reset. Check o_Loading=0, no o_LoadDone, o_TableValid=0, and sine outputs stay 0 until a new full load completes.
- Back-to-back random phases and modes against a reference model: all outputs match with exact 3-cycle alignment, including samples issued during the load-to-IDLE transition.

Source files
------------

// File: rtl/stage_multiwave_generator.sv
// Phase word to sine/triangle/sawtooth/square sample in three pipeline stages,
// with a quarter-wave sine table that is streamed in at runtime.
module stage_multiwave_generator #(
    parameter int PHASE_WIDTH      = 17,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int TABLE_ADDR_WIDTH = 14,
    parameter int SIDEBAND_WIDTH   = 24
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_Valid,
    input  logic [PHASE_WIDTH-1:0]    i_Phase,
    input  logic [1:0]                i_WaveSelect,
    input  logic [SIDEBAND_WIDTH-1:0] i_Sideband,
    output logic                      o_Valid,
    output logic [SAMPLE_WIDTH-1:0]   o_Waveform,
    output logic [SIDEBAND_WIDTH-1:0] o_Sideband,
    input  logic                      i_LoadStart,
    input  logic                      i_LoadValid,
    input  logic [SAMPLE_WIDTH-1:0]   i_LoadData,
    output logic                      o_Loading,
    output logic                      o_LoadDone,
    output logic                      o_TableValid
);
    localparam int DEPTH = 1 << TABLE_ADDR_WIDTH;
    localparam int UW    = PHASE_WIDTH - 1;
    localparam int SW    = SAMPLE_WIDTH;
    localparam int TAW   = TABLE_ADDR_WIDTH;

    localparam logic [1:0] SINE   = 2'd0;
    localparam logic [1:0] TRI    = 2'd1;
    localparam logic [1:0] SAW    = 2'd2;
    localparam logic [1:0] SQUARE = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        DONE
    } load_state_t;

    load_state_t    state, state_next;
    logic [TAW-1:0] count, count_next;
    logic           table_valid, table_valid_next;
    logic           write_en;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= IDLE;
            count       <= '0;
            table_valid <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            table_valid <= table_valid_next;
        end
    end

    always_comb begin
        state_next       = state;
        count_next       = count;
        table_valid_next = table_valid;
        write_en         = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_LoadStart) begin
                    state_next       = LOADING;
                    count_next       = '0;
                    table_valid_next = 1'b0;
                end
            end
            LOADING: begin
                if (i_LoadValid) begin
                    write_en   = 1'b1;
                    count_next = count + 1'b1;
                    if (&count) begin
                        state_next       = DONE;
                        table_valid_next = 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (i_Reset) write_en = 1'b0;
    end

    assign o_Loading    = (state == LOADING);
    assign o_LoadDone   = (state == DONE);
    assign o_TableValid = table_valid;

    // Stage 1: phase decode
    logic [UW-1:0]  pos;
    logic [1:0]     quad;
    logic [TAW-1:0] rel;
    logic           sine_mute;

    assign pos  = i_Phase[UW-1:0];
    assign quad = pos[UW-1 -: 2];
    assign rel  = pos[UW-3 -: TAW];
    // A lookup admitted on the load-start cycle would read while the
    // first writes own the port, so it is muted as well.
    assign sine_mute = o_Loading || !table_valid
                     || (state == IDLE && i_LoadStart);

    logic                      s1_valid;
    logic [1:0]                s1_mode;
    logic                      s1_neg;
    logic                      s1_mute;
    logic [TAW-1:0]            s1_addr;
    logic [SW-1:0]             s1_top;
    logic [SIDEBAND_WIDTH-1:0] s1_sideband;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            s1_valid    <= 1'b0;
            s1_mode     <= SINE;
            s1_neg      <= 1'b0;
            s1_mute     <= 1'b0;
            s1_addr     <= '0;
            s1_top      <= '0;
            s1_sideband <= '0;
        end else begin
            s1_valid    <= i_Valid;
            s1_mode     <= i_WaveSelect;
            s1_neg      <= quad[1];
            s1_mute     <= sine_mute;
            s1_addr     <= quad[0] ? ~rel : rel;
            s1_top      <= pos[UW-1 -: SW];
            s1_sideband <= i_Sideband;
        end
    end

    // Stage 2: table read (write owns the single port) and arithmetic waves
    logic [SW-2:0] table_mem [DEPTH];
    logic [SW-2:0] table_data;

    always_ff @(posedge i_Clock) begin
        if (write_en) table_mem[count] <= i_LoadData[SW-2:0];
        else          table_data <= table_mem[s1_addr];
    end

    logic [SW-2:0] tri_mag;
    logic [SW-1:0] alt_wave;

    always_comb begin
        tri_mag = '0;
        tri_mag[SW-2 -: TAW] = s1_addr;
        alt_wave = '0;
        unique case (s1_mode)
            TRI:     alt_wave = s1_neg ? ~{1'b0, tri_mag} : {1'b0, tri_mag};
            SAW:     alt_wave = {~s1_top[SW-1], s1_top[SW-2:0]};
            SQUARE:  alt_wave = s1_neg ? {1'b1, {(SW-1){1'b0}}}
                                       : {1'b0, {(SW-1){1'b1}}};
            default: alt_wave = '0;
        endcase
    end

    logic                      s2_valid;
    logic [1:0]                s2_mode;
    logic                      s2_neg;
    logic                      s2_mute;
    logic [SW-1:0]             s2_alt;
    logic [SIDEBAND_WIDTH-1:0] s2_sideband;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            s2_valid    <= 1'b0;
            s2_mode     <= SINE;
            s2_neg      <= 1'b0;
            s2_mute     <= 1'b0;
            s2_alt      <= '0;
            s2_sideband <= '0;
        end else begin
            s2_valid    <= s1_valid;
            s2_mode     <= s1_mode;
            s2_neg      <= s1_neg;
            s2_mute     <= s1_mute;
            s2_alt      <= alt_wave;
            s2_sideband <= s1_sideband;
        end
    end

    // Stage 3: mode mux, one's-complement negation for the sine
    logic [SW-1:0] sine_mag;
    logic [SW-1:0] wave_next;

    assign sine_mag = {1'b0, table_data};

    always_comb begin
        wave_next = s2_alt;
        if (s2_mode == SINE) begin
            if (s2_mute)     wave_next = '0;
            else if (s2_neg) wave_next = ~sine_mag;
            else             wave_next = sine_mag;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Valid    <= 1'b0;
            o_Waveform <= '0;
            o_Sideband <= '0;
        end else begin
            o_Valid    <= s2_valid;
            o_Waveform <= wave_next;
            o_Sideband <= s2_sideband;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{i_Phase[PHASE_WIDTH-1], i_LoadData[SW-1], pos};

endmodule
